conv_encoder_framer: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder with frame termination, sitting at the transmit end of the Viterbi link ahead of the channel/error-injection stage and the `decoder` block. It accepts one information bit per handshake and emits one registered 2-bit code symbol per accepted bit. After every `FRAME_LEN` information bits it appends K-1 = 2 zero tail bits, so each frame ends with the encoder in state 0, matching the decoder's zero-start/zero-end traceback assumption. It also marks frame boundaries and counts completed frames.

---
 rtl/conv_encoder_framer_if.sv | 21 ++
 rtl/conv_encoder_framer.sv | 124 ++++++++++++
 tb/tb_conv_encoder_framer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_framer_if.sv
// Bit-in / symbol-out handshake bundle for the convolutional encoder framer.
// The slave modport is the encoder side; master is the bit source / symbol sink.
interface conv_encoder_framer_if;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_sof;
    logic       out_eof;

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_sym, out_sof, out_eof
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_sym, out_sof, out_eof
    );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail frame termination.
// Emits one registered symbol per accepted bit plus two flush symbols per frame.
module conv_encoder_framer #(
    parameter int unsigned FRAME_LEN = 16,
    parameter logic [2:0]  G0        = 3'b111,
    parameter logic [2:0]  G1        = 3'b101
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_encoder_framer_if.slave bus,
    output logic [15:0]          frame_ct
);
    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    localparam logic [15:0] FLEN = 16'(FRAME_LEN);

    state_t      state_q, state_d;
    logic [1:0]  s_q, s_d;
    logic [15:0] bit_ct_q, bit_ct_d;
    logic        tail_q, tail_d;
    logic [15:0] frame_ct_q, frame_ct_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  out_sym_q, out_sym_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;

    logic        rdy;
    logic        xfer;
    logic        step;
    logic        d_bit;
    logic [2:0]  win;

    // Handshake and encode-step qualifiers; the tail flushes zeros unconditionally.
    assign rdy   = (state_q != TAIL);
    assign xfer  = bus.in_valid && rdy;
    assign step  = (state_q == TAIL) || xfer;
    assign d_bit = (state_q == TAIL) ? 1'b0 : bus.in_data;
    assign win   = {d_bit, s_q};

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            s_q         <= 2'b00;
            bit_ct_q    <= 16'd0;
            tail_q      <= 1'b0;
            frame_ct_q  <= 16'd0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            bit_ct_q    <= bit_ct_d;
            tail_q      <= tail_d;
            frame_ct_q  <= frame_ct_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Next state: shift register, bit count, tail phase and frame count.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bit_ct_d   = bit_ct_q;
        tail_d     = tail_q;
        frame_ct_d = frame_ct_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    s_d      = {d_bit, 1'b0};
                    bit_ct_d = 16'd1;
                    tail_d   = 1'b0;
                    state_d  = (FLEN == 16'd1) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    s_d      = {d_bit, s_q[1]};
                    bit_ct_d = bit_ct_q + 16'd1;
                    if (bit_ct_q + 16'd1 == FLEN) begin
                        tail_d  = 1'b0;
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                s_d = {1'b0, s_q[1]};
                if (!tail_q) begin
                    tail_d = 1'b1;
                end else begin
                    tail_d     = 1'b0;
                    s_d        = 2'b00;
                    bit_ct_d   = 16'd0;
                    frame_ct_d = frame_ct_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next registered outputs: parity symbol and frame markers.
    always_comb begin
        out_valid_d = step;
        out_sym_d   = 2'b00;
        if (step) begin
            out_sym_d = {^(win & G0), ^(win & G1)};
        end
        out_sof_d = xfer && (state_q == IDLE);
        out_eof_d = (state_q == TAIL) && tail_q;
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign frame_ct      = frame_ct_q;
endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench for conv_encoder_framer: random frames vs. a convolution model,
// plus fixed golden vectors, gapped input, mid-frame reset and a one-bit frame.
module tb_conv_encoder_framer;
    localparam int FL = 4;
    localparam logic [2:0] G0_T = 3'b111;
    localparam logic [2:0] G1_T = 3'b101;

    typedef struct {
        logic [1:0]  sym;
        logic        sof;
        logic        eof;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] fct;
    logic [15:0] fct1;

    conv_encoder_framer_if bi ();
    conv_encoder_framer_if bi1 ();

    conv_encoder_framer #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .bus(bi), .frame_ct(fct)
    );

    conv_encoder_framer #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bi1), .frame_ct(fct1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t expq[$];
    bit hist[$];
    int mfc = 0;
    logic [1:0] log_sym[$];
    logic [3:0] log1[$];
    int sym_count = 0;
    int low_rdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Symbol i of a frame is the GF(2) convolution of the frame bits with each generator.
    function automatic logic [1:0] ref_sym(input int i);
        int p1 = 0;
        int p0 = 0;
        for (int j = 0; j < 3; j++) begin
            int k = i - j;
            int u = (k >= 0) ? int'(hist[k]) : 0;
            if (G0_T[2-j]) p1 += u;
            if (G1_T[2-j]) p0 += u;
        end
        return {p1[0], p0[0]};
    endfunction

    task automatic model_bit(input bit b);
        exp_t e;
        int i;
        hist.push_back(b);
        i = hist.size() - 1;
        e.sym = ref_sym(i); e.sof = (i == 0); e.eof = 1'b0; e.fc = 16'(mfc);
        expq.push_back(e);
        if (hist.size() == FL) begin
            for (int t = 0; t < 2; t++) begin
                hist.push_back(1'b0);
                i = hist.size() - 1;
                e.sym = ref_sym(i); e.sof = 1'b0; e.eof = (t == 1);
                if (t == 1) mfc++;
                e.fc = 16'(mfc);
                expq.push_back(e);
            end
            hist.delete();
        end
    endtask

    task automatic idle(input int n);
        bi.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input bit b);
        bit done = 1'b0;
        bi.in_valid = 1'b1;
        bi.in_data = b;
        for (int t = 0; t < 8 && !done; t++) begin
            if (bi.in_ready) begin
                model_bit(b);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every presented symbol must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && bi.out_valid) begin
            sym_count++;
            log_sym.push_back(bi.out_sym);
            if (expq.size() == 0) begin
                chk("unexpected_symbol", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("sym", 32'(bi.out_sym), 32'(e.sym));
                chk("sof", 32'(bi.out_sof), 32'(e.sof));
                chk("eof", 32'(bi.out_eof), 32'(e.eof));
                chk("frame_ct", 32'(fct), 32'(e.fc));
            end
        end
        if (rst && !bi.in_ready) low_rdy++;
        if (rst && bi1.out_valid) log1.push_back({bi1.out_sof, bi1.out_eof, bi1.out_sym});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bi.out_valid), 32'd0);
        chk({tag, "_sym"}, 32'(bi.out_sym), 32'd0);
        chk({tag, "_sof"}, 32'(bi.out_sof), 32'd0);
        chk({tag, "_eof"}, 32'(bi.out_eof), 32'd0);
        chk({tag, "_fct"}, 32'(fct), 32'd0);
    endtask

    task automatic chk_golden(input string tag);
        logic [1:0] gold [6];
        gold = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        chk({tag, "_len"}, 32'(log_sym.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_sym.size(); i++)
            chk({tag, "_sym"}, 32'(log_sym[i]), 32'(gold[i]));
    endtask

    initial begin
        bi.in_valid = 1'b0; bi.in_data = 1'b0;
        bi1.in_valid = 1'b0; bi1.in_data = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        low_rdy = 0;
        log_sym.delete();
        send(1); send(0); send(1); send(1);
        idle(4);
        chk_golden("golden");
        chk("golden_rdy_low", 32'(low_rdy), 32'd2);
        chk("golden_fct", 32'(fct), 32'd1);

        log_sym.delete();
        send(1); send(0);
        idle(3);
        send(1); send(1);
        idle(4);
        chk_golden("gapped");
        chk("gapped_fct", 32'(fct), 32'd2);

        sym_count = 0;
        for (int f = 0; f < 10; f++) begin
            for (int b = 0; b < FL; b++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send(1'($urandom));
            end
        end
        idle(4);
        chk("b2b_symbols", 32'(sym_count), 32'(10 * (FL + 2)));
        chk("b2b_fct", 32'(fct), 32'd12);

        send(1); send(1); send(0);
        idle(2);
        rst = 1'b0;
        hist.delete();
        mfc = 0;
        chk("abort_queue_empty", 32'(expq.size()), 32'd0);
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        for (int b = 0; b < FL; b++) send(1'($urandom));
        idle(4);
        chk("after_reset_fct", 32'(fct), 32'd1);

        log1.delete();
        bi1.in_valid = 1'b1; bi1.in_data = 1'b1;
        @(posedge clk); #1;
        bi1.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("fl1_len", 32'(log1.size()), 32'd3);
        if (log1.size() == 3) begin
            chk("fl1_s0", 32'(log1[0]), 32'b1011);
            chk("fl1_s1", 32'(log1[1]), 32'b0010);
            chk("fl1_s2", 32'(log1[2]), 32'b0111);
        end
        chk("fl1_fct", 32'(fct1), 32'd1);

        chk("final_queue_empty", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
